// File: rtl/mips16_pkg.sv
// Shared definitions for the multi-cycle 16-bit-instruction MIPS subset core:
// opcodes, FSM states, instruction field positions, ALU ops and sign extension.
package mips16_pkg;

   localparam int MAX_W = 64;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_SLT  = 4'h4;
   localparam logic [3:0] OP_ADDI = 4'h5;
   localparam logic [3:0] OP_LW   = 4'h6;
   localparam logic [3:0] OP_SW   = 4'h7;
   localparam logic [3:0] OP_BEQ  = 4'h8;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam int OP_MSB  = 15;
   localparam int OP_LSB  = 12;
   localparam int RS_MSB  = 11;
   localparam int RS_LSB  = 10;
   localparam int RT_MSB  = 9;
   localparam int RT_LSB  = 8;
   localparam int RD_MSB  = 7;
   localparam int RD_LSB  = 6;
   localparam int IMM_MSB = 7;
   localparam int IMM_LSB = 0;

   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_e;

   typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

   // Sign-extends imm8 to 'width' bits; bits above 'width' are zero.
   function automatic logic [MAX_W-1:0] sext8(input logic [7:0] imm, input int unsigned width);
      logic [MAX_W-1:0] r;
      r = {{(MAX_W-8){imm[7]}}, imm};
      if (width < MAX_W) r &= (MAX_W'(1) << width) - MAX_W'(1);
      return r;
   endfunction

   function automatic logic is_rtype(input logic [3:0] op);
      return op <= OP_SLT;
   endfunction

   function automatic logic is_illegal(input logic [3:0] op);
      return op inside {[4'h9:4'hE]};
   endfunction

endpackage

// File: rtl/mips_regfile_p.sv
// 4-entry register file, two combinational read ports and one write port.
// r0 always reads zero; writes to it are discarded.
module mips_regfile_p #(
   parameter int DATA_W = 16
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              we,
   input  logic [1:0]        waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [1:0]        raddr1,
   output logic [DATA_W-1:0] rdata1,
   input  logic [1:0]        raddr2,
   output logic [DATA_W-1:0] rdata2
);

   logic [DATA_W-1:0] regs_q [0:3];
   logic [DATA_W-1:0] regs_d [0:3];

   always_comb begin
      regs_d[0] = '0;
      for (int i = 1; i < 4; i++) begin
         regs_d[i] = regs_q[i];
         if (we && waddr == 2'(i)) regs_d[i] = wdata;
      end
   end

   // NOTE: the array is reset explicitly because the core's reset state defines every register as zero.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 4; i++) regs_q[i] <= '0;
      end else begin
         // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
         for (int i = 0; i < 4; i++) regs_q[i] <= regs_d[i];
      end
   end

   assign rdata1 = regs_q[raddr1];
   assign rdata2 = regs_q[raddr2];

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS subset core: one shared ALU, FSM-sequenced, with req/ack
// instruction and data memory ports that tolerate wait states.
module mips_multicycle_core
   import mips16_pkg::*;
#(
   parameter int              DATA_W   = 16,
   parameter int              PC_W     = 16,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic              clock,
   input  logic              reset_n,
   output logic              imem_req,
   output logic [PC_W-1:0]   imem_addr,
   input  logic              imem_ack,
   input  logic [15:0]       imem_rdata,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_ack,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic              retire,
   output logic [DATA_W-1:0] retire_wd,
   output logic [PC_W-1:0]   pc_o,
   output logic              halted,
   output logic              illegal
);

   state_e            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [15:0]       ir_q, ir_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d, wb_q, wb_d;
   logic              imem_req_q, imem_req_d;
   logic              dmem_req_q, dmem_req_d, dmem_we_q, dmem_we_d;
   logic [DATA_W-1:0] dmem_addr_q, dmem_addr_d, dmem_wdata_q, dmem_wdata_d;
   logic              retire_q, retire_d;
   logic [DATA_W-1:0] retire_wd_q, retire_wd_d;
   logic              halted_q, halted_d, illegal_q, illegal_d;

   logic [3:0]        op;
   logic [1:0]        rs, rt, rd;
   logic [DATA_W-1:0] imm_ext, alu_b, alu_y, rf_rdata1, rf_rdata2;
   logic [PC_W-1:0]   imm_pc, pc_inc;
   alu_op_e           alu_op;

   assign op      = ir_q[OP_MSB:OP_LSB];
   assign rs      = ir_q[RS_MSB:RS_LSB];
   assign rt      = ir_q[RT_MSB:RT_LSB];
   assign rd      = ir_q[RD_MSB:RD_LSB];
   assign imm_ext = DATA_W'(sext8(ir_q[IMM_MSB:IMM_LSB], DATA_W));
   assign imm_pc  = PC_W'(sext8(ir_q[IMM_MSB:IMM_LSB], PC_W));
   assign pc_inc  = pc_q + PC_W'(1);

   mips_regfile_p #(.DATA_W(DATA_W)) u_regfile (
      .clock  (clock),
      .reset_n(reset_n),
      .we     (state_q == WB),
      .waddr  (is_rtype(op) ? rd : rt),
      .wdata  (wb_q),
      .raddr1 (rs),
      .rdata1 (rf_rdata1),
      .raddr2 (rt),
      .rdata2 (rf_rdata2)
   );

   always_comb begin
      unique case (op)
         OP_SUB:  alu_op = ALU_SUB;
         OP_AND:  alu_op = ALU_AND;
         OP_OR:   alu_op = ALU_OR;
         OP_SLT:  alu_op = ALU_SLT;
         default: alu_op = ALU_ADD;
      endcase
   end

   assign alu_b = is_rtype(op) ? b_q : imm_ext;

   always_comb begin
      unique case (alu_op)
         ALU_SUB: alu_y = a_q - alu_b;
         ALU_AND: alu_y = a_q & alu_b;
         ALU_OR:  alu_y = a_q | alu_b;
         ALU_SLT: alu_y = {{(DATA_W-1){1'b0}}, $signed(a_q) < $signed(alu_b)};
         default: alu_y = a_q + alu_b;
      endcase
   end

   // NOTE: every _d gets its hold value first so no path through the case leaves one unassigned (no latches).
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      ir_d         = ir_q;
      a_d          = a_q;
      b_d          = b_q;
      wb_d         = wb_q;
      imem_req_d   = imem_req_q;
      dmem_req_d   = dmem_req_q;
      dmem_we_d    = dmem_we_q;
      dmem_addr_d  = dmem_addr_q;
      dmem_wdata_d = dmem_wdata_q;
      retire_d     = 1'b0;
      retire_wd_d  = '0;
      halted_d     = halted_q;
      illegal_d    = illegal_q;

      case (state_q)
         FETCH: begin
            // Out of reset the request comes up one edge late, so addr and req rise together.
            if (!imem_req_q) begin
               imem_req_d = 1'b1;
            end else if (imem_ack) begin
               ir_d       = imem_rdata;
               imem_req_d = 1'b0;
               state_d    = DECODE;
            end
         end
         DECODE: begin
            a_d = rf_rdata1;
            b_d = rf_rdata2;
            if (op == OP_HALT) begin
               halted_d = 1'b1;
               state_d  = HALT;
            end else if (is_illegal(op)) begin
               halted_d  = 1'b1;
               illegal_d = 1'b1;
               state_d   = HALT;
            end else begin
               state_d = EXEC;
            end
         end
         EXEC: begin
            if (op == OP_BEQ) begin
               pc_d       = (a_q == b_q) ? pc_inc + imm_pc : pc_inc;
               retire_d   = 1'b1;
               imem_req_d = 1'b1;
               state_d    = FETCH;
            end else if (op == OP_LW || op == OP_SW) begin
               dmem_req_d   = 1'b1;
               dmem_we_d    = (op == OP_SW);
               dmem_addr_d  = alu_y;
               dmem_wdata_d = b_q;
               state_d      = MEM;
            end else begin
               wb_d    = alu_y;
               state_d = WB;
            end
         end
         MEM: begin
            if (dmem_ack) begin
               dmem_req_d = 1'b0;
               dmem_we_d  = 1'b0;
               if (dmem_we_q) begin
                  retire_d   = 1'b1;
                  pc_d       = pc_inc;
                  imem_req_d = 1'b1;
                  state_d    = FETCH;
               end else begin
                  wb_d    = dmem_rdata;
                  state_d = WB;
               end
            end
         end
         WB: begin
            retire_d    = 1'b1;
            retire_wd_d = wb_q;
            pc_d        = pc_inc;
            imem_req_d  = 1'b1;
            state_d     = FETCH;
         end
         default: state_d = state_q;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= FETCH;
         pc_q         <= RESET_PC;
         ir_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         wb_q         <= '0;
         imem_req_q   <= 1'b0;
         dmem_req_q   <= 1'b0;
         dmem_we_q    <= 1'b0;
         dmem_addr_q  <= '0;
         dmem_wdata_q <= '0;
         retire_q     <= 1'b0;
         retire_wd_q  <= '0;
         halted_q     <= 1'b0;
         illegal_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         ir_q         <= ir_d;
         a_q          <= a_d;
         b_q          <= b_d;
         wb_q         <= wb_d;
         imem_req_q   <= imem_req_d;
         dmem_req_q   <= dmem_req_d;
         dmem_we_q    <= dmem_we_d;
         dmem_addr_q  <= dmem_addr_d;
         dmem_wdata_q <= dmem_wdata_d;
         retire_q     <= retire_d;
         retire_wd_q  <= retire_wd_d;
         halted_q     <= halted_d;
         illegal_q    <= illegal_d;
      end
   end

   assign imem_req   = imem_req_q;
   assign imem_addr  = pc_q;
   assign dmem_req   = dmem_req_q;
   assign dmem_we    = dmem_we_q;
   assign dmem_addr  = dmem_addr_q;
   assign dmem_wdata = dmem_wdata_q;
   assign retire     = retire_q;
   assign retire_wd  = retire_wd_q;
   assign pc_o       = pc_q;
   assign halted     = halted_q;
   assign illegal    = illegal_q;

endmodule
